// File: rtl/modinv_param_pkg.sv
// Shared types and defaults for the parametrised modular divider.
package modinv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Binary EEA needs at most ~2*(2*WIDTH) steps; the margin covers the finish cycle.
    function automatic int default_max_iter(input int width);
        return 4 * width + 8;
    endfunction

endpackage

// File: rtl/modinv_param_if.sv
// Request/result bundle between the ECC sequencer (master) and the divider (slave).
interface modinv_param_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] c;
    logic             ready;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, b, a, m,
        input  c, ready, busy, done, err
    );

    modport slave (
        input  start, b, a, m,
        output c, ready, busy, done, err
    );
endinterface

// File: rtl/modinv_param_step.sv
// One binary extended-Euclid step; purely combinational, residues kept in [0, m-1].
module modinv_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] i_u,
    input  logic [WIDTH-1:0] i_v,
    input  logic [WIDTH-1:0] i_x1,
    input  logic [WIDTH-1:0] i_x2,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_u,
    output logic [WIDTH-1:0] o_v,
    output logic [WIDTH-1:0] o_x1,
    output logic [WIDTH-1:0] o_x2,
    output logic             o_u_one,
    output logic             o_v_one,
    output logic             o_zero
);

    logic [WIDTH:0]   w_x1_half_sum;
    logic [WIDTH:0]   w_x2_half_sum;
    logic [WIDTH-1:0] w_x1_sub;
    logic [WIDTH-1:0] w_x2_sub;

    // Adding m to an odd residue makes it even without changing its class; the carry needs WIDTH+1 bits.
    assign w_x1_half_sum = {1'b0, i_x1} + (i_x1[0] ? {1'b0, i_m} : '0);
    assign w_x2_half_sum = {1'b0, i_x2} + (i_x2[0] ? {1'b0, i_m} : '0);

    // Wrap-around in WIDTH bits is exact here because the true result is below m.
    assign w_x1_sub = (i_x1 >= i_x2) ? (i_x1 - i_x2) : (i_x1 - i_x2 + i_m);
    assign w_x2_sub = (i_x2 >= i_x1) ? (i_x2 - i_x1) : (i_x2 - i_x1 + i_m);

    assign o_u_one = (i_u == WIDTH'(1));
    assign o_v_one = (i_v == WIDTH'(1));
    assign o_zero  = (i_u == '0) || (i_v == '0);

    always_comb begin
        o_u  = i_u;
        o_v  = i_v;
        o_x1 = i_x1;
        o_x2 = i_x2;
        if (!i_u[0]) begin
            o_u  = i_u >> 1;
            o_x1 = w_x1_half_sum[WIDTH:1];
        end else if (!i_v[0]) begin
            o_v  = i_v >> 1;
            o_x2 = w_x2_half_sum[WIDTH:1];
        end else if (i_u >= i_v) begin
            o_u  = i_u - i_v;
            o_x1 = w_x1_sub;
        end else begin
            o_v  = i_v - i_u;
            o_x2 = w_x2_sub;
        end
    end

endmodule

// File: rtl/modinv_param.sv
// Iterative modular divider c = b * a^-1 mod m (odd m) with input checks, timeout and done pulse.
// state | meaning
// IDLE  | post-reset, no result yet
// CHECK | validate latched operands
// RUN   | one Euclid step per cycle
// DONE  | result/err valid, waiting for next start
module modinv_param
    import modinv_pkg::*;
#(
    parameter int WIDTH    = 256,
    parameter int MAX_ITER = default_max_iter(WIDTH)
) (
    input logic           clk,
    input logic           rst_n,
    modinv_param_if.slave bus
);

    localparam int ITER_W = $clog2(MAX_ITER + 2);

    state_t            r_state;
    logic [WIDTH-1:0]  r_u;
    logic [WIDTH-1:0]  r_v;
    logic [WIDTH-1:0]  r_x1;
    logic [WIDTH-1:0]  r_x2;
    logic [WIDTH-1:0]  r_m;
    logic [WIDTH-1:0]  r_c;
    logic [ITER_W-1:0] r_iter;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    state_t            w_state_nxt;
    logic [WIDTH-1:0]  w_u_nxt;
    logic [WIDTH-1:0]  w_v_nxt;
    logic [WIDTH-1:0]  w_x1_nxt;
    logic [WIDTH-1:0]  w_x2_nxt;
    logic [WIDTH-1:0]  w_m_nxt;
    logic [WIDTH-1:0]  w_c_nxt;
    logic [ITER_W-1:0] w_iter_nxt;
    logic              w_ready_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;

    logic [WIDTH-1:0]  w_step_u;
    logic [WIDTH-1:0]  w_step_v;
    logic [WIDTH-1:0]  w_step_x1;
    logic [WIDTH-1:0]  w_step_x2;
    logic              w_u_one;
    logic              w_v_one;
    logic              w_zero;
    logic              w_bad_input;
    logic              w_iter_max;

    modinv_step #(.WIDTH(WIDTH)) u_step (
        .i_u     (r_u),
        .i_v     (r_v),
        .i_x1    (r_x1),
        .i_x2    (r_x2),
        .i_m     (r_m),
        .o_u     (w_step_u),
        .o_v     (w_step_v),
        .o_x1    (w_step_x1),
        .o_x2    (w_step_x2),
        .o_u_one (w_u_one),
        .o_v_one (w_v_one),
        .o_zero  (w_zero)
    );

    // Operands are checked from the latched copies so the master may change the bus after start.
    assign w_bad_input = !r_m[0] || (r_m < WIDTH'(3)) || (r_u == '0)
                      || (r_u >= r_m) || (r_x1 >= r_m);
    assign w_iter_max  = (r_iter == ITER_W'(MAX_ITER));

    always_comb begin
        w_state_nxt = r_state;
        w_u_nxt     = r_u;
        w_v_nxt     = r_v;
        w_x1_nxt    = r_x1;
        w_x2_nxt    = r_x2;
        w_m_nxt     = r_m;
        w_c_nxt     = r_c;
        w_iter_nxt  = r_iter;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_u_nxt     = bus.a;
                    w_v_nxt     = bus.m;
                    w_x1_nxt    = bus.b;
                    w_x2_nxt    = '0;
                    w_m_nxt     = bus.m;
                    w_iter_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_bad_input) begin
                    w_err_nxt   = 1'b1;
                    w_c_nxt     = '0;
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_iter_nxt = r_iter + ITER_W'(1);
                if (w_u_one || w_v_one || w_zero || w_iter_max) begin
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                    if (w_u_one) begin
                        w_c_nxt = r_x1;
                    end else if (w_v_one) begin
                        w_c_nxt = r_x2;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_c_nxt   = '0;
                    end
                end else begin
                    w_u_nxt  = w_step_u;
                    w_v_nxt  = w_step_v;
                    w_x1_nxt = w_step_x1;
                    w_x2_nxt = w_step_x2;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_u     <= '0;
            r_v     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_m     <= '0;
            r_c     <= '0;
            r_iter  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_u     <= w_u_nxt;
            r_v     <= w_v_nxt;
            r_x1    <= w_x1_nxt;
            r_x2    <= w_x2_nxt;
            r_m     <= w_m_nxt;
            r_c     <= w_c_nxt;
            r_iter  <= w_iter_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.c     = r_c;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_modinv_param.sv
// Directed and random checks of modinv_param at WIDTH 8, 16 and 256.
module tb_modinv_param;

    localparam int MI8   = 4 * 8 + 8;
    localparam int MI16  = 4 * 16 + 8;
    localparam int MI256 = 4 * 256 + 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    modinv_param_if #(.WIDTH(8))   if8 ();
    modinv_param_if #(.WIDTH(16))  if16 ();
    modinv_param_if #(.WIDTH(256)) if256 ();

    modinv_param #(.WIDTH(8))   u_dut8   (.clk(clk), .rst_n(rst_n), .bus(if8));
    modinv_param #(.WIDTH(16))  u_dut16  (.clk(clk), .rst_n(rst_n), .bus(if16));
    modinv_param #(.WIDTH(256)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

    int           sel;
    logic [255:0] s_c;
    logic         s_ready, s_busy, s_done, s_err;
    int           n_chk  = 0;
    int           n_fail = 0;

    always_comb begin
        case (sel)
            0: begin
                s_c = 256'(if8.c); s_ready = if8.ready; s_busy = if8.busy;
                s_done = if8.done; s_err = if8.err;
            end
            1: begin
                s_c = 256'(if16.c); s_ready = if16.ready; s_busy = if16.busy;
                s_done = if16.done; s_err = if16.err;
            end
            default: begin
                s_c = if256.c; s_ready = if256.ready; s_busy = if256.busy;
                s_done = if256.done; s_err = if256.err;
            end
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] c;
        bit         e;
        int         lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic drive(input int s, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] m, input logic st);
        case (s)
            0: begin if8.a = a[7:0]; if8.b = b[7:0]; if8.m = m[7:0]; if8.start = st; end
            1: begin if16.a = a[15:0]; if16.b = b[15:0]; if16.m = m[15:0]; if16.start = st; end
            default: begin if256.a = a; if256.b = b; if256.m = m; if256.start = st; end
        endcase
    endtask

    // Entered on the negedge after the start-sampling edge; lat = edge at which done is seen.
    task automatic wait_done(input int limit, output int lat);
        int e;
        e   = 0;
        lat = -1;
        while (!s_done && e < limit) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        if (s_done) begin
            lat = e + 1;
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: no done within %0d edges (sel %0d)", limit + 1, sel);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic run_op(input int s, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] m, input int limit,
                          output logic [255:0] c, output logic e, output int lat);
        sel = s;
        drive(s, a, b, m, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(s, a, b, m, 1'b0);
        chk("busy_after_start", 256'(s_busy), 256'(1));
        chk("ready_after_start", 256'(s_ready), 256'(0));
        wait_done(limit, lat);
        c = s_c;
        e = s_err;
        if (lat > 0) chk("ready_at_done", 256'(s_ready), 256'(1));
    endtask

    function automatic int unsigned gcd(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    logic [255:0] res_c;
    logic         res_e;
    int           res_lat;
    logic [255:0] p256;
    logic [255:0] a256;
    logic [511:0] prod;

    initial begin
        vecs[0]  = '{8'd3,   8'd1,   8'd17,  8'd6,   1'b0, 0};
        vecs[1]  = '{8'd3,   8'd5,   8'd17,  8'd13,  1'b0, 0};
        vecs[2]  = '{8'd1,   8'd7,   8'd17,  8'd7,   1'b0, 3};
        vecs[3]  = '{8'd6,   8'd1,   8'd15,  8'd0,   1'b1, 0};
        vecs[4]  = '{8'd0,   8'd5,   8'd17,  8'd0,   1'b1, 2};
        vecs[5]  = '{8'd3,   8'd1,   8'd16,  8'd0,   1'b1, 2};
        vecs[6]  = '{8'd3,   8'd17,  8'd17,  8'd0,   1'b1, 2};
        vecs[7]  = '{8'd17,  8'd1,   8'd17,  8'd0,   1'b1, 2};
        vecs[8]  = '{8'd1,   8'd0,   8'd1,   8'd0,   1'b1, 2};
        vecs[9]  = '{8'd5,   8'd4,   8'd19,  8'd16,  1'b0, 0};
        vecs[10] = '{8'd2,   8'd1,   8'd255, 8'd128, 1'b0, 0};
        vecs[11] = '{8'd254, 8'd1,   8'd255, 8'd254, 1'b0, 0};
        vecs[12] = '{8'd1,   8'd254, 8'd255, 8'd254, 1'b0, 3};
        vecs[13] = '{8'd7,   8'd0,   8'd17,  8'd0,   1'b0, 0};
        vecs[14] = '{8'd2,   8'd1,   8'd3,   8'd2,   1'b0, 0};

        sel = 0;
        drive(0, '0, '0, '0, 1'b0);
        drive(1, '0, '0, '0, 1'b0);
        drive(2, '0, '0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_c", s_c, '0);
        chk("reset_ready", 256'(s_ready), 256'(0));
        chk("reset_busy", 256'(s_busy), 256'(0));
        chk("reset_done", 256'(s_done), 256'(0));
        chk("reset_err", 256'(s_err), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(0, 256'(vecs[i].a), 256'(vecs[i].b), 256'(vecs[i].m), MI8 + 2,
                   res_c, res_e, res_lat);
            chk($sformatf("vec%0d_c", i), res_c, 256'(vecs[i].c));
            chk($sformatf("vec%0d_err", i), 256'(res_e), 256'(vecs[i].e));
            if (vecs[i].lat != 0)
                chk($sformatf("vec%0d_lat", i), 256'(res_lat), 256'(vecs[i].lat));
            else
                chk($sformatf("vec%0d_lat_bound", i), 256'(res_lat > 0 && res_lat <= MI8 + 3), 256'(1));
            @(negedge clk);
            chk($sformatf("vec%0d_done_width", i), 256'(s_done), 256'(0));
        end

        // start held high through the busy window, operands changed underneath
        sel = 0;
        drive(0, 256'd3, 256'd5, 256'd17, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 256'd7, 256'd2, 256'd15, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_no_early_done", 256'(s_done), 256'(0));
        end
        drive(0, 256'd7, 256'd2, 256'd15, 1'b0);
        wait_done(MI8 + 2, res_lat);
        chk("hold_c", s_c, 256'd13);
        chk("hold_err", 256'(s_err), 256'(0));
        @(negedge clk);
        chk("hold_single_done", 256'(s_done), 256'(0));

        // second start pulse in the middle of a run
        drive(0, 256'd3, 256'd1, 256'd17, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 256'd3, 256'd1, 256'd17, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 256'd5, 256'd1, 256'd19, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 256'd5, 256'd1, 256'd19, 1'b0);
        wait_done(MI8 + 2, res_lat);
        chk("midstart_c", s_c, 256'd6);
        chk("midstart_err", 256'(s_err), 256'(0));
        @(negedge clk);

        // reset dropped mid-run
        drive(0, 256'd3, 256'd5, 256'd17, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 256'd3, 256'd5, 256'd17, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 256'(s_busy), 256'(0));
        chk("rst_mid_ready", 256'(s_ready), 256'(0));
        chk("rst_mid_c", s_c, '0);
        chk("rst_mid_done", 256'(s_done), 256'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_done", 256'(s_done), 256'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", 256'(s_done), 256'(0));
        run_op(0, 256'd3, 256'd5, 256'd17, MI8 + 2, res_c, res_e, res_lat);
        chk("post_rst_c", res_c, 256'd13);
        chk("post_rst_err", 256'(res_e), 256'(0));
        @(negedge clk);

        // secp256k1 field prime
        p256 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
        a256 = 256'hFED5B7E8_1A2B3C4D_5E6F7081_92A3B4C5_D6E7F809_1A2B3C4D_5E6F7081_0791219A;
        run_op(2, a256, 256'd1, p256, MI256 + 2, res_c, res_e, res_lat);
        prod = ({256'b0, res_c} * {256'b0, a256}) % {256'b0, p256};
        chk("w256_err", 256'(res_e), 256'(0));
        chk("w256_c_range", 256'(res_c < p256), 256'(1));
        chk("w256_inverse", prod[255:0], 256'd1);
        chk("w256_lat_bound", 256'(res_lat > 0 && res_lat <= MI256 + 3), 256'(1));
        @(negedge clk);

        // random regression, every run after the first starts on the previous done cycle
        for (int i = 0; i < 1000; i++) begin
            int unsigned rm, ra, rb, g;
            longint unsigned rp;
            rm = $urandom_range(3, 65535) | 32'd1;
            ra = $urandom_range(1, rm - 1);
            rb = $urandom_range(0, rm - 1);
            g  = gcd(ra, rm);
            run_op(1, 256'(ra), 256'(rb), 256'(rm), MI16 + 2, res_c, res_e, res_lat);
            if (g == 1) begin
                rp = (longint'(res_c[15:0]) * longint'(ra)) % longint'(rm);
                chk($sformatf("rnd%0d_err m=%0d a=%0d", i, rm, ra), 256'(res_e), 256'(0));
                chk($sformatf("rnd%0d_ca_mod_m m=%0d a=%0d b=%0d", i, rm, ra, rb), 256'(rp), 256'(rb));
            end else begin
                chk($sformatf("rnd%0d_err m=%0d a=%0d", i, rm, ra), 256'(res_e), 256'(1));
                chk($sformatf("rnd%0d_c0", i), res_c, '0);
            end
        end
        @(negedge clk);
        chk("rnd_final_done_width", 256'(s_done), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/modinv_param.md
Name: modinv_param

Overview:
- Parametrised, iterative modular divider: computes c = b * a^-1 mod m for odd modulus m, WIDTH bits, using the binary extended Euclidean algorithm.
- Successor to the fixed 256-bit modinv used by the ECC core.
- Adds a WIDTH parameter, input validation, a non-invertible/timeout error flag, and a one-cycle done pulse.
- Sits under the ECC point-arithmetic sequencer; one operation in flight at a time.

Parameters:
- WIDTH, 256, operand/modulus width in bits (>= 4).
- MAX_ITER, 4*WIDTH+8, RUN-cycle limit before timeout error is declared.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- b  in  WIDTH  numerator, must be < m.
- a  in  WIDTH  value to invert, must satisfy 0 < a < m.
- m  in  WIDTH  modulus, must be odd and >= 3.
- c  out  WIDTH  result, registered; held until next start.
- ready  out  1  level: result/err valid; set on finish, cleared on accepted start.
- busy  out  1  high from accepted start until finish.
- done  out  1  single-cycle pulse on the cycle ready rises.
- err  out  1  valid with ready: 1 = invalid input, gcd(a,m)!=1, or timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; c=0, ready=0, busy=0, done=0, err=0; internal u,v,x1,x2,iter cleared. Reset mid-operation aborts the run with no done pulse.
- States:
  - IDLE/DONE: start=1 at a posedge loads u=a, v=m, x1=b, x2=0, iter=0 and latches m internally. Same edge sets busy=1, ready=0, err=0, then goes to CHECK. Inputs may change after this edge.
  - CHECK (1 cycle): if m even, m<3, a==0, a>=m or b>=m, then err=1, c=0, go to DONE. Otherwise go to RUN.
  - RUN, one action per cycle, first match wins:
    - u==1: c=x1, go to DONE.
    - v==1: c=x2, go to DONE.
    - u==0 or v==0: err=1, c=0, go to DONE.
    - iter==MAX_ITER: err=1, c=0, go to DONE.
    - u even: u=u>>1, x1=half(x1).
    - v even: v=v>>1, x2=half(x2).
    - u>=v: u=u-v, x1=msub(x1,x2).
    - else: v=v-u, x2=msub(x2,x1).
    - iter increments every RUN cycle.
- Entering DONE: busy=0, ready=1, done=1 for exactly one cycle.
- start while busy=1 is ignored.
- start in DONE begins a new run; ready drops on that edge.
- Arithmetic:
  - half(x) = x>>1 if x even, else (x+m)>>1, computed in WIDTH+1 bits.
  - msub(x,y) = x-y if x>=y, else x-y+m.
  - x1, x2 always in [0, m-1].
- Latency, counted in posedges after the start-sampling edge:
  - invalid input: done at edge 2.
  - a=1: done at edge 3.
  - general case: <= MAX_ITER+3.

Decomposition:
- Package modinv_pkg holds the state enum (IDLE, CHECK, RUN, DONE) and the default MAX_ITER function of WIDTH.
- Sub-module modinv_step: purely combinational. Inputs: u, v, x1, x2, m. Outputs: next u, v, x1, x2 and the finish/err flags.
- The top module holds the FSM, registers and iteration counter.

Test Plan:
1. WIDTH=8, m=17, a=3, b=1, pulse start -> done pulse once, ready=1, err=0, c=6.
2. WIDTH=8, m=17, a=3, b=5 -> c=13. Then a=1, b=7 -> c=7, done exactly 3 edges after start.
3. WIDTH=8, m=15, a=6, b=1 -> err=1, c=0 (gcd 3). Separately a=0 -> err=1 at edge 2; m=16 -> err=1 at edge 2.
4. WIDTH=256, m=FFFFFFFF...FFFFFFFEFFFFFC2F, a=FED5B7E8...0791219A, b=1 -> err=0, (c*a) mod m == 1 per reference model, done within MAX_ITER+3 edges.
5. Start held high during busy, second start pulse mid-run, rst_n dropped mid-run:
   - extra starts ignored;
   - reset immediately clears busy/ready/c with no done pulse;
   - a fresh start after reset yields the correct result.
6. Random WIDTH=16 regression, 1000 odd m with random a, b < m:
   - c*a mod m == b whenever gcd(a,m)=1, else err=1;
   - back-to-back start issued on the DONE cycle is accepted.
